// File: rtl/rv_main_decoder.sv
// rv_main_decoder: registered control unit for the RV32I core.
// Decodes opcode, funct3, instruction bit 30 and the ALU zero flag into
// the datapath control word. The whole word is flopped, so a decode
// appears one clock after its inputs are sampled.
module rv_main_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       zero,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic       alu_src,
  output logic       mem_write,
  output logic [1:0] result_src,
  output logic       branch,
  output logic       jump,
  output logic [2:0] alu_control,
  output logic       pc_src,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  logic       regWrite_d,   regWrite_q;
  logic [1:0] immSrc_d,     immSrc_q;
  logic       aluSrc_d,     aluSrc_q;
  logic       memWrite_d,   memWrite_q;
  logic [1:0] resultSrc_d,  resultSrc_q;
  logic       branch_d,     branch_q;
  logic       jump_d,       jump_q;
  logic [2:0] aluControl_d, aluControl_q;
  logic       pcSrc_d,      pcSrc_q;
  logic       illegal_d,    illegal_q;
  logic [1:0] aluOp;

  // Main decode: opcode selects the instruction class and its control fields.
  always_comb begin
    regWrite_d  = 1'b0;
    immSrc_d    = 2'b00;
    aluSrc_d    = 1'b0;
    memWrite_d  = 1'b0;
    resultSrc_d = 2'b00;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    aluOp       = 2'b00;
    illegal_d   = 1'b0;
    case (op)
      OP_LOAD: begin
        regWrite_d  = 1'b1;
        aluSrc_d    = 1'b1;
        resultSrc_d = 2'b01;
      end
      OP_STORE: begin
        immSrc_d   = 2'b01;
        aluSrc_d   = 1'b1;
        memWrite_d = 1'b1;
      end
      OP_RTYPE: begin
        regWrite_d = 1'b1;
        aluOp      = 2'b10;
      end
      OP_BRANCH: begin
        immSrc_d = 2'b10;
        branch_d = 1'b1;
        aluOp    = 2'b01;
      end
      OP_IALU: begin
        regWrite_d = 1'b1;
        aluSrc_d   = 1'b1;
        aluOp      = 2'b10;
      end
      OP_JAL: begin
        regWrite_d  = 1'b1;
        immSrc_d    = 2'b11;
        resultSrc_d = 2'b10;
        jump_d      = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // ALU decode: subtract only for R-type with bit 30 set; I-type always adds.
  always_comb begin
    aluControl_d = ALU_ADD;
    case (aluOp)
      2'b01: aluControl_d = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  aluControl_d = (op[5] && funct7) ? ALU_SUB : ALU_ADD;
          3'b001:  aluControl_d = ALU_SLL;
          3'b010:  aluControl_d = ALU_SLT;
          3'b100:  aluControl_d = ALU_XOR;
          3'b101:  aluControl_d = ALU_SRL;
          3'b110:  aluControl_d = ALU_OR;
          3'b111:  aluControl_d = ALU_AND;
          default: aluControl_d = ALU_ADD;
        endcase
      end
      default: aluControl_d = ALU_ADD;
    endcase
  end

  // Next-PC select: funct3[0] inverts the sense of the zero flag (beq/bne).
  always_comb begin
    pcSrc_d = jump_d | (branch_d & (zero ^ funct3[0]));
  end

  // Output register; reset loads an all-zero NOP control word.
  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite_q   <= 1'b0;
      immSrc_q     <= 2'b00;
      aluSrc_q     <= 1'b0;
      memWrite_q   <= 1'b0;
      resultSrc_q  <= 2'b00;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      aluControl_q <= 3'b000;
      pcSrc_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      regWrite_q   <= regWrite_d;
      immSrc_q     <= immSrc_d;
      aluSrc_q     <= aluSrc_d;
      memWrite_q   <= memWrite_d;
      resultSrc_q  <= resultSrc_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      aluControl_q <= aluControl_d;
      pcSrc_q      <= pcSrc_d;
      illegal_q    <= illegal_d;
    end
  end

  assign reg_write   = regWrite_q;
  assign imm_src     = immSrc_q;
  assign alu_src     = aluSrc_q;
  assign mem_write   = memWrite_q;
  assign result_src  = resultSrc_q;
  assign branch      = branch_q;
  assign jump        = jump_q;
  assign alu_control = aluControl_q;
  assign pc_src      = pcSrc_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_rv_main_decoder.sv
// tb_rv_main_decoder: self-checking bench for rv_main_decoder.
// A behavioural model predicts the control word from the instruction
// class; a compare process checks every cycle, and directed literal
// expectations pin the model.
module tb_rv_main_decoder;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic       reg_write;
  logic [1:0] imm_src;
  logic       alu_src;
  logic       mem_write;
  logic [1:0] result_src;
  logic       branch;
  logic       jump;
  logic [2:0] alu_control;
  logic       pc_src;
  logic       illegal;

  int compared;
  int mismatched;

  logic [13:0] expWord;
  logic        expValid;
  logic        stopCompare;

  rv_main_decoder dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .zero(zero), .reg_write(reg_write), .imm_src(imm_src),
    .alu_src(alu_src), .mem_write(mem_write), .result_src(result_src),
    .branch(branch), .jump(jump), .alu_control(alu_control),
    .pc_src(pc_src), .illegal(illegal)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control word layout used for comparisons:
  // {reg_write, imm_src, alu_src, mem_write, result_src, branch, jump,
  //  alu_control, pc_src, illegal}
  function automatic logic [13:0] pack(input logic rw, input logic [1:0] imm,
                                       input logic as, input logic mw,
                                       input logic [1:0] rs, input logic br,
                                       input logic j, input logic [2:0] ac,
                                       input logic pc, input logic il);
    return {rw, imm, as, mw, rs, br, j, ac, pc, il};
  endfunction

  function automatic logic [13:0] dutWord();
    return pack(reg_write, imm_src, alu_src, mem_write, result_src, branch,
                jump, alu_control, pc_src, illegal);
  endfunction

  // Reference model: instruction class first, then the operation it performs.
  function automatic logic [13:0] model(input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic z);
    logic [2:0] aluByF3 [8];
    logic [2:0] ac;
    logic       taken;
    aluByF3[0] = 3'd0; aluByF3[1] = 3'd6; aluByF3[2] = 3'd5; aluByF3[3] = 3'd0;
    aluByF3[4] = 3'd4; aluByF3[5] = 3'd7; aluByF3[6] = 3'd3; aluByF3[7] = 3'd2;
    ac = aluByF3[f3];
    taken = (f3[0] == 1'b0) ? (z == 1'b1) : (z == 1'b0);
    if (o == 7'd3)        return pack(1, 2'd0, 1, 0, 2'd1, 0, 0, 3'd0, 0, 0);
    else if (o == 7'd35)  return pack(0, 2'd1, 1, 1, 2'd0, 0, 0, 3'd0, 0, 0);
    else if (o == 7'd51)  return pack(1, 2'd0, 0, 0, 2'd0, 0, 0,
                                      (f3 == 3'd0 && f7) ? 3'd1 : ac, 0, 0);
    else if (o == 7'd19)  return pack(1, 2'd0, 1, 0, 2'd0, 0, 0, ac, 0, 0);
    else if (o == 7'd99)  return pack(0, 2'd2, 0, 0, 2'd0, 1, 0, 3'd1, taken, 0);
    else if (o == 7'd111) return pack(1, 2'd3, 0, 0, 2'd2, 0, 1, 3'd0, 1, 0);
    else                  return pack(0, 2'd0, 0, 0, 2'd0, 0, 0, 3'd0, 0, 1);
  endfunction

  // Predict the registered word from the inputs sampled at each rising edge.
  always @(posedge clk) begin
    expWord  = rst ? 14'd0 : model(op, funct3, funct7, zero);
    expValid = 1'b1;
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (expValid && !stopCompare) begin
      compared++;
      if (dutWord() !== expWord) begin
        mismatched++;
        $display("[TB] FAIL model-compare t=%0t: dut=%b expected=%b", $time, dutWord(), expWord);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic [31:0] instr, input logic z);
    rst    = r;
    op     = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[30];
    zero   = z;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [13:0] want);
    compared++;
    if (dutWord() !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: dut=%b expected=%b", name, dutWord(), want);
    end
  endtask

  logic [6:0] legalOps [6];

  initial begin
    logic [31:0] instr;
    compared    = 0;
    mismatched  = 0;
    expValid    = 1'b0;
    stopCompare = 1'b0;
    expWord     = 14'd0;
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0;
    #1;

    applyStimulus(1, 32'h00000033, 0);
    applyStimulus(1, 32'h00000033, 0);
    checkOutput("reset", 14'd0);
    applyStimulus(0, 32'h00000000, 0);
    checkOutput("illegal-op0", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(0, 32'h00500113, 0);
    checkOutput("addi", pack(1, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0));
    applyStimulus(0, 32'hFF718393, 0);
    checkOutput("addi-bit30", pack(1, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0));
    applyStimulus(0, 32'h0023E233, 0);
    checkOutput("or", pack(1, 0, 0, 0, 0, 0, 0, 3'b011, 0, 0));
    applyStimulus(0, 32'h0041F2B3, 0);
    checkOutput("and", pack(1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0));
    applyStimulus(0, 32'h004282B3, 0);
    checkOutput("add", pack(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0));
    applyStimulus(0, 32'h40000033, 0);
    checkOutput("sub", pack(1, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0));
    applyStimulus(0, 32'h00002003, 0);
    checkOutput("lw", pack(1, 2'b00, 1, 0, 2'b01, 0, 0, 3'b000, 0, 0));
    applyStimulus(0, 32'h00002023, 0);
    checkOutput("sw", pack(0, 2'b01, 1, 1, 2'b00, 0, 0, 3'b000, 0, 0));
    applyStimulus(0, 32'h00000063, 1);
    checkOutput("beq-taken", pack(0, 2'b10, 0, 0, 0, 1, 0, 3'b001, 1, 0));
    applyStimulus(0, 32'h00000063, 0);
    checkOutput("beq-not", pack(0, 2'b10, 0, 0, 0, 1, 0, 3'b001, 0, 0));
    applyStimulus(0, 32'h00001063, 0);
    checkOutput("bne-taken", pack(0, 2'b10, 0, 0, 0, 1, 0, 3'b001, 1, 0));
    applyStimulus(0, 32'h00001063, 1);
    checkOutput("bne-not", pack(0, 2'b10, 0, 0, 0, 1, 0, 3'b001, 0, 0));
    applyStimulus(0, 32'h0000006F, 0);
    checkOutput("jal", pack(1, 2'b11, 0, 0, 2'b10, 0, 1, 3'b000, 1, 0));
    applyStimulus(1, 32'h0000006F, 0);
    checkOutput("reset-midstream", 14'd0);
    applyStimulus(0, 32'h00500113, 0);
    checkOutput("after-reset", pack(1, 0, 1, 0, 0, 0, 0, 3'b000, 0, 0));

    legalOps[0] = 7'b0000011; legalOps[1] = 7'b0100011; legalOps[2] = 7'b0110011;
    legalOps[3] = 7'b1100011; legalOps[4] = 7'b0010011; legalOps[5] = 7'b1101111;
    for (int i = 0; i < 400; i++) begin
      instr = $urandom;
      if ($urandom_range(0, 7) != 0) instr[6:0] = legalOps[$urandom_range(0, 5)];
      applyStimulus(($urandom_range(0, 19) == 0), instr, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    stopCompare = 1'b1;
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv_main_decoder.md
Name: rv_main_decoder

Overview:
- Control unit for the RV32I core.
- Decodes opcode, funct3, instruction bit 30 and the ALU zero flag into datapath control signals: register write, immediate select, ALU operand select, memory write, result select, ALU operation and next-PC select.
- All outputs are registered, so the control word appears one clock after its inputs. An illegal-opcode flag is also provided.

Parameters:
- None. Encodings are fixed as given below.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- op  input  7  instruction[6:0]
- funct3  input  3  instruction[14:12]
- funct7  input  1  instruction[30]
- zero  input  1  ALU result-equals-zero flag
- reg_write  output  1  register file write enable
- imm_src  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
- alu_src  output  1  ALU operand B select: 0 register, 1 immediate
- mem_write  output  1  data memory write enable
- result_src  output  2  writeback select: 00 ALU, 01 memory, 10 PC+4
- branch  output  1  instruction is a conditional branch
- jump  output  1  instruction is jal
- alu_control  output  3  ALU operation code
- pc_src  output  1  next-PC select: 1 = branch/jump target
- illegal  output  1  unsupported opcode

Behaviour:
- Clocking and reset
  - Every output is a flop updated on the rising edge of clk.
  - Latency is exactly 1 cycle: inputs sampled at edge N give outputs valid after edge N.
  - rst=1 at an edge forces every output to 0 (a NOP control word), regardless of inputs. This holds for reset asserted mid-stream too; the first decode after rst deasserts uses inputs sampled at that edge.
- Main decode (op to reg_write, imm_src, alu_src, mem_write, result_src, branch, alu_op, jump):
  - 0000011 lw: 1, 00, 1, 0, 01, 0, 00, 0
  - 0100011 sw: 0, 01, 1, 1, 00, 0, 00, 0
  - 0110011 R-type: 1, 00, 0, 0, 00, 0, 10, 0
  - 1100011 branch: 0, 10, 0, 0, 00, 1, 01, 0
  - 0010011 I-ALU: 1, 00, 1, 0, 00, 0, 10, 0
  - 1101111 jal: 1, 11, 0, 0, 10, 0, 00, 1
  - Any other op: all controls 0 and illegal=1; otherwise illegal=0. Don't-care fields are driven to 0.
- alu_op is an internal 2-bit signal.
- alu_control encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl.
- ALU decode
  - alu_op=00: add.
  - alu_op=01: sub.
  - alu_op=10, selected by funct3:
    - 000: sub only if op[5]=1 and funct7=1, else add. An I-type with instr[30]=1 still adds.
    - 001: sll
    - 010: slt
    - 100: xor
    - 101: srl
    - 110: or
    - 111: and
    - 011: add
- pc_src = jump OR (branch AND (zero XOR funct3[0])).
  - funct3=000 is beq, taken when zero=1.
  - funct3=001 is bne, taken when zero=0.
  - Other branch funct3 values use the same bit-0 rule.
- pc_src is registered with the rest, computed from the zero value sampled on the same edge.
- No internal state beyond the output registers; no handshake.

Test Plan:
- Reset and illegal opcode
  - Hold rst=1 for 2 cycles with op=0110011 -> all outputs 0.
  - Release rst with instruction 0x00000000 (op=0) -> illegal=1, all controls 0.
- addi 0x00500113 and 0xFF718393 (op=0010011, funct3=000, funct7=0 and 1)
  - Next cycle: reg_write=1, imm_src=00, alu_src=1, result_src=00, alu_control=000, mem_write=0, pc_src=0, illegal=0.
- R-type or/and/add: 0x0023E233, 0x0041F2B3, 0x004282B3 on consecutive cycles
  - alu_control=011, then 010, then 000, each one cycle later; reg_write=1, alu_src=0.
  - sub 0x40000033 -> alu_control=001.
- Loads and stores
  - lw (op=0000011) -> result_src=01, alu_src=1, reg_write=1.
  - sw (op=0100011) -> mem_write=1, imm_src=01, reg_write=0.
- Branch and jump
  - beq (op=1100011, funct3=000): zero=1 -> pc_src=1, alu_control=001, branch=1; zero=0 -> pc_src=0.
  - bne (funct3=001): zero=0 -> pc_src=1.
  - jal (op=1101111) -> jump=1, pc_src=1, imm_src=11, result_src=10.
- Reset mid-stream
  - Assert rst during a jal cycle -> next cycle all outputs 0.
  - Deassert rst -> following decode is correct after 1 cycle.
